hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Central pipeline sequencing controller for the 5-stage RISC-V core. Each cycle it decides the write-enable, flush and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It covers three hazard sources:
- load-use stalls, detected from the ID-stage instruction;
- branch/jump redirects resolved in EX;
- multi-cycle data-memory/MMIO waits, guarded by a watchdog.
It also keeps saturating performance counters for stall and flush activity.

Parameters:
MEM_TIMEOUT, 255, maximum freeze cycles per data access before forced release (≥2)
CNT_W, 32, width of performance counters

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_inst  input  32  instruction currently in ID
ex_mem_read  input  1  EX-stage instruction is a load
ex_rd  input  5  EX-stage destination register
ex_redirect  input  1  EX resolved taken branch / JAL / JALR (PC mux selects target)
mem_req  input  1  MEM stage issues a data access this cycle
mem_ready  input  1  data memory / MMIO completes access this cycle
pc_we  output  1  PC register write enable
if_id_we  output  1  IF/ID write enable
if_id_flush  output  1  IF/ID load NOP
id_ex_flush  output  1  ID/EX load bubble
ex_mem_we  output  1  EX/MEM write enable
mem_wb_bubble  output  1  MEM/WB load bubble
stall_cycles  output  CNT_W  cycles with pc_we=0 since reset, saturating
flush_count  output  CNT_W  redirects acted on since reset, saturating
mem_timeout_err  output  1  sticky; set on any watchdog release

Behaviour:
- Register-use decode from id_inst[6:0]:
  - rs1 used by the R, I, L, JALR, S and B opcodes.
  - rs2 used by the R, S and B opcodes.
  - LUI, AUIPC, JAL and unknown opcodes use neither.
  - rs1 = id_inst[19:15], rs2 = id_inst[24:20].
  - Register x0 is never a hazard.
- FSM states RUN and MEM_WAIT, plus a wait_cnt register (8 bits, or wide enough for MEM_TIMEOUT).
- freeze condition:
  - In RUN: mem_req & !mem_ready. Next state MEM_WAIT, wait_cnt←1.
  - In MEM_WAIT with mem_ready=1: no freeze. Pipeline advances this cycle; next state RUN.
  - In MEM_WAIT with mem_ready=0 and wait_cnt==MEM_TIMEOUT: no freeze. Forced release, mem_timeout_err←1, next state RUN.
  - In MEM_WAIT otherwise: freeze, wait_cnt++.
  - Result: at most MEM_TIMEOUT freeze cycles per access.
- RUN with mem_req & mem_ready: single-cycle access, no freeze.
- Output priority, evaluated combinationally from state and inputs; pipeline registers act on the next edge:
  1. freeze: pc_we=0, if_id_we=0, id_ex_flush=0, ex_mem_we=0, mem_wb_bubble=1, if_id_flush=0. ex_redirect is ignored; it stays asserted because EX is held, and is acted on at release.
  2. ex_redirect: pc_we=1, if_id_we=1, if_id_flush=1, id_ex_flush=1, ex_mem_we=1. Redirect overrides a simultaneous load-use hit.
  3. load-use (ex_mem_read & ex_rd≠0 & register match): pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1.
  4. Default: all enables 1, all flushes/bubbles 0.
- Counters:
  - stall_cycles increments every cycle with pc_we=0 while out of reset.
  - flush_count increments every cycle in which priority 2 is taken.
  - Both saturate at all-ones, with no wrap.
- Reset (asynchronous, rst_n low):
  - state=RUN, wait_cnt=0, counters=0, mem_timeout_err=0.
  - While asserted, outputs are forced to pc_we=0, if_id_we=0, ex_mem_we=0, if_id_flush=1, id_ex_flush=1, mem_wb_bubble=1.
  - Reset mid-MEM_WAIT abandons the access; no error is recorded.
- mem_timeout_err clears only on reset.
- A release cycle with mem_req also asserted for a new access starts no new wait in that same cycle. The next access is evaluated in RUN on the following cycle.

Decomposition:
- OPCODE_R/I/L/S/B/JALR/JAL/LUI/AUIPC macros come from the shared riscv_defs header; no local opcode constants.
- One sub-module, hazard_ctrl_mem_fsm: RUN/MEM_WAIT state, wait_cnt and watchdog. It outputs freeze and timeout_pulse.
- Register-use decode and the priority mux stay in the top level.

Test Plan:
- Load-use: EX = lw x5 (ex_mem_read=1, ex_rd=5); ID = add x6,x5,x7 (0x00728333) → exactly one cycle of pc_we=0, if_id_we=0, id_ex_flush=1; stall_cycles=1. Same case with ID = lui x5 → no stall.
- x0 and rs2 filtering: ex_rd=0 with ex_mem_read=1 and an ID instruction reading x0 → no stall. ex_rd=7, ID = sw x7,0(x2) (rs2 match) → stall. ex_rd=7, ID = jal x7 → no stall.
- Redirect vs load-use: ex_redirect=1 together with a load-use match → if_id_flush=1, id_ex_flush=1, pc_we=1; flush_count increments by 1; stall_cycles unchanged.
- MMIO wait: mem_req=1 with mem_ready low for 3 cycles then high → 3 freeze cycles (mem_wb_bubble=1, pc_we=0), release on the 4th cycle, state back to RUN, no error. A redirect pending during the freeze is acted on at release.
- Watchdog: MEM_TIMEOUT=4, mem_ready held 0 → 4 freeze cycles, forced release on the 5th cycle, mem_timeout_err=1 and sticky thereafter.
- Reset: assert rst_n=0 asynchronously while in MEM_WAIT with counters nonzero → outputs immediately take the reset values; after release, state=RUN, counters=0, err=0, and the pipeline advances normally.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic {StRun, StMemWait} mem_state_e;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_we;
    logic mem_wb_bubble;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CtrlAdvance  = 6'b110010;
  localparam pipe_ctrl_t CtrlFreeze   = 6'b000001;
  localparam pipe_ctrl_t CtrlRedirect = 6'b111110;
  localparam pipe_ctrl_t CtrlLoadUse  = 6'b000110;
  localparam pipe_ctrl_t CtrlReset    = 6'b001101;

  // Wait counter is at least 8 bits, wider only if the timeout needs it.
  function automatic int unsigned wait_cnt_w(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mem_fsm.sv
// Data-memory wait tracker: freezes the pipeline while an access is outstanding and
// forces a release after MEM_TIMEOUT freeze cycles.
module hazard_ctrl_mem_fsm
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_req,
  input  logic mem_ready,
  output logic freeze,
  output logic timeout_pulse
);

  localparam int unsigned WaitW = wait_cnt_w(MEM_TIMEOUT);

  mem_state_e       state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    freeze        = 1'b0;
    timeout_pulse = 1'b0;
    case (state_q)
      StRun: begin
        if (mem_req && !mem_ready) begin
          freeze     = 1'b1;
          state_d    = StMemWait;
          wait_cnt_d = WaitW'(1);
        end
      end
      StMemWait: begin
        // A release cycle never re-arms; a new request is seen from RUN next cycle.
        if (mem_ready) begin
          state_d = StRun;
        end else if (wait_cnt_q == WaitW'(MEM_TIMEOUT)) begin
          timeout_pulse = 1'b1;
          state_d       = StRun;
        end else begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      default: state_d = StRun;
    endcase
  end

endmodule

// File: rtl/riscv_defs.svh
// Shared RV32 base opcode encodings (inst[6:0]) used across the core.
`ifndef RISCV_DEFS_SVH
`define RISCV_DEFS_SVH

`define OPCODE_R     7'b0110011
`define OPCODE_I     7'b0010011
`define OPCODE_L     7'b0000011
`define OPCODE_S     7'b0100011
`define OPCODE_B     7'b1100011
`define OPCODE_JALR  7'b1100111
`define OPCODE_JAL   7'b1101111
`define OPCODE_LUI   7'b0110111
`define OPCODE_AUIPC 7'b0010111

`endif

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, EX redirects and memory-wait freezes,
// plus saturating stall/flush counters.
`include "riscv_defs.svh"

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_inst,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_we,
  output logic             mem_wb_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout_err
);

  logic       freeze, timeout_pulse;
  logic       use_rs1, use_rs2, load_use, redirect_taken;
  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  pipe_ctrl_t ctrl;
  logic       unused_inst_bits;

  logic [CNT_W-1:0] stall_q, flush_q;
  logic             err_q;

  assign opcode           = id_inst[6:0];
  assign rs1              = id_inst[19:15];
  assign rs2              = id_inst[24:20];
  assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:7]};

  hazard_ctrl_mem_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_fsm (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .freeze        (freeze),
    .timeout_pulse (timeout_pulse)
  );

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      `OPCODE_R, `OPCODE_S, `OPCODE_B: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      `OPCODE_I, `OPCODE_L, `OPCODE_JALR: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));

  // Redirect is held off during a freeze; EX keeps presenting it until release.
  assign redirect_taken = rst_n && !freeze && ex_redirect;

  always_comb begin
    ctrl = CtrlAdvance;
    if (!rst_n) begin
      ctrl = CtrlReset;
    end else if (freeze) begin
      ctrl = CtrlFreeze;
    end else if (ex_redirect) begin
      ctrl = CtrlRedirect;
    end else if (load_use) begin
      ctrl = CtrlLoadUse;
    end
  end

  assign pc_we         = ctrl.pc_we;
  assign if_id_we      = ctrl.if_id_we;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign ex_mem_we     = ctrl.ex_mem_we;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (!ctrl.pc_we && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (redirect_taken && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
      if (timeout_pulse) err_q <= 1'b1;
    end
  end

  assign stall_cycles    = stall_q;
  assign flush_count     = flush_q;
  assign mem_timeout_err = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expectations, a monitor checks.
module tb_hazard_ctrl;

  localparam int unsigned MemTimeout = 4;
  localparam int unsigned CntW       = 3;
  localparam int          CntMax     = 7;

  localparam logic [5:0] Adv = 6'b110010;
  localparam logic [5:0] Frz = 6'b000001;
  localparam logic [5:0] Red = 6'b111110;
  localparam logic [5:0] Lu  = 6'b000110;
  localparam logic [5:0] Rst = 6'b001101;

  localparam logic [31:0] Nop     = 32'h0000_0013;
  localparam logic [31:0] AddX5X7 = 32'h0072_8333;
  localparam logic [31:0] LuiX5   = 32'h0002_92B7;
  localparam logic [31:0] AddX0X0 = 32'h0000_0333;
  localparam logic [31:0] SwX7    = 32'h0071_2023;
  localparam logic [31:0] JalX7   = 32'h0073_83EF;
  localparam logic [31:0] AddiX1  = 32'h0070_8413;

  logic            clk, rst_n;
  logic [31:0]     id_inst;
  logic            ex_mem_read, ex_redirect, mem_req, mem_ready;
  logic [4:0]      ex_rd;
  logic            pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_bubble;
  logic [CntW-1:0] stall_cycles, flush_count;
  logic            mem_timeout_err;

  typedef struct {
    logic [5:0] ctrl;
    int         stall;
    int         flush;
    logic       err;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_stall = 0;
  int   acc_flush = 0;

  hazard_ctrl #(
    .MEM_TIMEOUT (MemTimeout),
    .CNT_W       (CntW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_inst         (id_inst),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_redirect     (ex_redirect),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_we           (pc_we),
    .if_id_we        (if_id_we),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_we       (ex_mem_we),
    .mem_wb_bubble   (mem_wb_bubble),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count),
    .mem_timeout_err (mem_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counters observed in a cycle reflect every earlier cycle's expected controls.
  task automatic step(input logic rst, input logic [31:0] inst, input logic mr,
                      input logic [4:0] rd, input logic redir, input logic req,
                      input logic rdy, input logic [5:0] ctrl, input logic err,
                      input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n       = rst;
    id_inst     = inst;
    ex_mem_read = mr;
    ex_rd       = rd;
    ex_redirect = redir;
    mem_req     = req;
    mem_ready   = rdy;
    if (!rst) begin
      acc_stall = 0;
      acc_flush = 0;
    end
    e.ctrl  = ctrl;
    e.stall = acc_stall;
    e.flush = acc_flush;
    e.err   = err;
    e.name  = name;
    exp_q.push_back(e);
    if (rst && !ctrl[5] && acc_stall < CntMax) acc_stall++;
    if (rst && ctrl[5] && ctrl[3] && acc_flush < CntMax) acc_flush++;
  endtask

  initial begin : monitor
    exp_t       e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_bubble};
        checks++;
        if (act !== e.ctrl) begin
          errors++;
          $display("FAIL %s ctrl: got %b want %b", e.name, act, e.ctrl);
        end
        checks++;
        if (int'(stall_cycles) != e.stall) begin
          errors++;
          $display("FAIL %s stall_cycles: got %0d want %0d", e.name, stall_cycles, e.stall);
        end
        checks++;
        if (int'(flush_count) != e.flush) begin
          errors++;
          $display("FAIL %s flush_count: got %0d want %0d", e.name, flush_count, e.flush);
        end
        checks++;
        if (mem_timeout_err !== e.err) begin
          errors++;
          $display("FAIL %s mem_timeout_err: got %b want %b", e.name, mem_timeout_err, e.err);
        end
      end
    end
  end

  initial begin : stimulus
    int budget;
    rst_n = 1'b0; id_inst = Nop; ex_mem_read = 1'b0; ex_rd = 5'd0;
    ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    //   rst  inst     mr  rd  red req rdy  exp  err  name
    step(0, Nop,     0, 0, 0, 0, 0, Rst, 0, "reset");
    step(1, Nop,     0, 0, 0, 0, 0, Adv, 0, "run");
    step(1, AddX5X7, 1, 5, 0, 0, 0, Lu,  0, "loaduse_add");
    step(1, AddX5X7, 0, 5, 0, 0, 0, Adv, 0, "after_stall");
    step(1, LuiX5,   1, 5, 0, 0, 0, Adv, 0, "lui_nostall");
    step(1, AddX0X0, 1, 0, 0, 0, 0, Adv, 0, "x0_nostall");
    step(1, SwX7,    1, 7, 0, 0, 0, Lu,  0, "sw_rs2_stall");
    step(1, JalX7,   1, 7, 0, 0, 0, Adv, 0, "jal_nostall");
    step(1, AddiX1,  1, 7, 0, 0, 0, Adv, 0, "itype_no_rs2");
    step(1, AddX5X7, 1, 5, 1, 0, 0, Red, 0, "redirect_over_lu");
    step(1, Nop,     0, 0, 0, 0, 0, Adv, 0, "after_redirect");
    step(1, Nop,     0, 0, 1, 1, 0, Frz, 0, "mmio_frz1");
    step(1, Nop,     0, 0, 1, 1, 0, Frz, 0, "mmio_frz2");
    step(1, Nop,     0, 0, 1, 1, 0, Frz, 0, "mmio_frz3");
    step(1, Nop,     0, 0, 1, 1, 1, Red, 0, "mmio_release_redir");
    step(1, Nop,     0, 0, 0, 0, 0, Adv, 0, "mmio_done");
    step(1, Nop,     0, 0, 0, 1, 1, Adv, 0, "single_cycle_access");
    step(1, Nop,     0, 0, 0, 1, 0, Frz, 0, "wd_frz1");
    step(1, Nop,     0, 0, 0, 1, 0, Frz, 0, "wd_frz2");
    step(1, Nop,     0, 0, 0, 1, 0, Frz, 0, "wd_frz3_sat");
    step(1, Nop,     0, 0, 0, 1, 0, Frz, 0, "wd_frz4_sat");
    step(1, Nop,     0, 0, 0, 1, 0, Adv, 0, "wd_forced_release");
    step(1, Nop,     0, 0, 0, 1, 0, Frz, 1, "new_wait_after_release");
    step(1, Nop,     0, 0, 0, 1, 1, Adv, 1, "ready_release");
    step(1, Nop,     0, 0, 0, 0, 0, Adv, 1, "err_sticky");
    step(1, Nop,     0, 0, 0, 1, 0, Frz, 1, "pre_reset_wait");
    step(0, Nop,     0, 0, 0, 1, 0, Rst, 0, "async_reset");
    step(1, Nop,     0, 0, 0, 0, 0, Adv, 0, "post_reset_run");
    step(1, AddX5X7, 1, 5, 0, 0, 0, Lu,  0, "post_reset_lu");
    step(1, Nop,     0, 0, 0, 0, 0, Adv, 0, "post_reset_cnt");
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
